// File: rtl/xrun_pkg.sv
// ----------------------------------------------------------------------------
// xrun_pkg
// Shared definitions for the picoVersat boot-run-dump sequencer (xrun_seq).
//   - state_t : 3-bit sequencer state encoding
//   - R0_ADDR : register-file address of the run/handshake register R0
// Data and address widths are parameters of xrun_seq; their defaults match
// DATA_W / REGF_ADDR_W in xdefs.vh.
// Optional feature macro used by the sequencer: XRUN_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package xrun_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_ADDR   = 3'd4;
    localparam logic [2:0] S_LOAD   = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_WRITE  = S_WRITE,
        ST_SETTLE = S_SETTLE,
        ST_POLL   = S_POLL,
        ST_ADDR   = S_ADDR,
        ST_LOAD   = S_LOAD,
        ST_OUT    = S_OUT,
        ST_FIN    = S_FIN
    } state_t;

    // R0 doubles as the start flag: the host writes non-zero, the core clears it.
    localparam int unsigned R0_ADDR = 0;

endpackage

// File: rtl/xrun_cnt.sv
// ----------------------------------------------------------------------------
// xrun_cnt
// Saturating up-counter with synchronous clear/enable and a limit compare.
// Used by xrun_seq both as the execution cycle counter and as the timeout
// reference (hit_o).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   clr_i  in   synchronous clear (wins over en_i)
//   en_i   in   count enable; holds at all-ones once reached
//   lim_i  in   compare limit; 0 disables hit_o
//   cnt_o  out  current count
//   hit_o  out  cnt_o == lim_i and lim_i != 0
// ----------------------------------------------------------------------------
module xrun_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] lim_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (lim_i != '0) && (cnt_q == lim_i);

endmodule

// File: rtl/xrun_seq.sv
// ----------------------------------------------------------------------------
// xrun_seq
// Boot-run-dump sequencer for the picoVersat register-file parallel port.
// Writes START_VAL to R0, polls R0 until the core clears it while counting
// cycles, then streams every register out over a valid/ready interface.
// Optional feature macro: XRUN_TIMEOUT_EN (poll timeout via timeout_lim).
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   one-cycle launch pulse, accepted only when idle
//   busy         out  high from accepted start until the FIN state
//   done         out  one-cycle pulse at dump completion or timeout abort
//   timed_out    out  sticky timeout flag, cleared by an accepted start
//   cycles       out  execution cycle count of the last run
//   timeout_lim  in   poll limit (0 = no limit); used only with timeouts on
//   par_addr/par_we/par_in  out  register-file parallel port to xtop
//   par_out      in   register data, valid one cycle after par_addr
//   dump_valid/dump_ready   valid/ready handshake of the dump stream
//   dump_addr/dump_data     out  register index and contents
// ----------------------------------------------------------------------------
module xrun_seq
    import xrun_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4,
    parameter int START_VAL   = 1,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [CNT_W-1:0]       cycles,
    input  logic [CNT_W-1:0]       timeout_lim,
    output logic [REGF_ADDR_W-1:0] par_addr,
    output logic                   par_we,
    output logic [DATA_W-1:0]      par_in,
    input  logic [DATA_W-1:0]      par_out,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [REGF_ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0]      dump_data
);

    localparam logic [DATA_W-1:0]      START_WORD = DATA_W'(START_VAL);
    localparam logic [REGF_ADDR_W-1:0] R0         = REGF_ADDR_W'(R0_ADDR);
    localparam logic [REGF_ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [REGF_ADDR_W-1:0] ADDR_ONE   = {{(REGF_ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timed_out_q;
    logic [REGF_ADDR_W-1:0] par_addr_q;
    logic                   par_we_q;
    logic [DATA_W-1:0]      par_in_q;
    logic                   dump_valid_q;
    logic [REGF_ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0]      dump_data_q;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_lim;
    logic [CNT_W-1:0] cnt_val;
    logic             poll_zero;
    logic             abort;

    assign poll_zero = (par_out == '0);
    assign cnt_clr   = (state_q == ST_IDLE) && start;

`ifdef XRUN_TIMEOUT_EN
    assign cnt_lim = timeout_lim;
    // Abort only while R0 is still set; a zero seen on the limit cycle wins.
    assign abort   = (state_q == ST_POLL) && cnt_hit && !poll_zero;
`else
    logic unused_timeout;
    assign cnt_lim        = '0;
    assign abort          = 1'b0;
    assign unused_timeout = ^{timeout_lim, cnt_hit};
`endif

    // The aborting poll cycle is not counted, so cycles reads back the limit.
    assign cnt_en = (state_q == ST_POLL) && !abort;

    xrun_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .lim_i (cnt_lim),
        .cnt_o (cnt_val),
        .hit_o (cnt_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            par_addr_q   <= '0;
            par_we_q     <= 1'b0;
            par_in_q     <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    par_addr_q <= R0;
                    par_we_q   <= 1'b0;
                    if (start) begin
                        state_q     <= ST_WRITE;
                        busy_q      <= 1'b1;
                        timed_out_q <= 1'b0;
                        // Registered port: the write is presented during WRITE.
                        par_we_q    <= 1'b1;
                        par_in_q    <= START_WORD;
                    end
                end
                ST_WRITE: begin
                    par_we_q <= 1'b0;
                    par_in_q <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // One spare cycle so the first POLL sample reflects the write.
                    state_q <= ST_POLL;
                end
                ST_POLL: begin
                    if (abort) begin
                        timed_out_q <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (poll_zero) begin
                        par_addr_q <= R0;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    dump_data_q  <= par_out;
                    dump_addr_q  <= par_addr_q;
                    dump_valid_q <= 1'b1;
                    state_q      <= ST_OUT;
                end
                ST_OUT: begin
                    if (dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (par_addr_q == LAST_ADDR) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            par_addr_q <= par_addr_q + ADDR_ONE;
                            state_q    <= ST_ADDR;
                        end
                    end
                end
                ST_FIN: begin
                    par_addr_q <= R0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign timed_out  = timed_out_q;
    assign cycles     = cnt_val;
    assign par_addr   = par_addr_q;
    assign par_we     = par_we_q;
    assign par_in     = par_in_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;

endmodule
